// File: rtl/alu_nibble_sequencer.sv
// Purpose: runs a WIDTH-bit ALU op through one external 4-bit combinational slice, LSB nibble first.
// Latency: done pulses NIBBLES clocks after start is accepted; the next start is accepted in the done cycle.
// Backpressure: start is sampled only in IDLE; a start while busy is dropped, with no queueing.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start, op_a/op_b/op_s/op_m/op_cin   request and operands, latched on accept
//   busy, done             operation in progress / one-cycle completion pulse
//   result, cout, zero     registered outcome, updated together on completion
//   alu_a/alu_b/alu_s/alu_m/alu_cin     drive to the slice (all 0 in IDLE)
//   alu_o, alu_cout        slice outputs, captured each RUN cycle
module alu_nibble_sequencer #(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op_s,
  input  logic             op_m,
  input  logic             op_cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cin,
  input  logic [3:0]       alu_o,
  input  logic             alu_cout
);

  localparam int              IDXW     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [3:0]         s_q, s_d;
  logic               m_q, m_d, cin_q, cin_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d, zero_q, zero_d;
  logic               busy_q, busy_d, done_q, done_d;

  // Bit offset of the current nibble; two extra bits give 4*idx without overflow.
  logic [IDXW+1:0]    nib_lsb;
  assign nib_lsb = {idx_q, 2'b00};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    m_d      = m_q;
    cin_d    = cin_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    alu_a    = 4'd0;
    alu_b    = 4'd0;
    alu_s    = 4'd0;
    alu_m    = 1'b0;
    alu_cin  = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          s_d     = op_s;
          m_d     = op_m;
          cin_d   = op_cin;
          idx_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        alu_a   = a_q[nib_lsb +: 4];
        alu_b   = b_q[nib_lsb +: 4];
        alu_s   = s_q;
        alu_m   = m_q;
        // Carry is chained raw in both modes; the slice decides what it means.
        alu_cin = (idx_q == '0) ? cin_q : carry_q;

        acc_d[nib_lsb +: 4] = alu_o;
        carry_d             = alu_cout;

        if (idx_q == LAST_IDX) begin
          // acc_d already holds this last nibble, so result is complete here.
          result_d = acc_d;
          cout_d   = alu_cout;
          zero_d   = (acc_d == '0);
          done_d   = 1'b1;
          busy_d   = 1'b0;
          idx_d    = '0;
          state_d  = IDLE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      m_q      <= m_d;
      cin_q    <= cin_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer with NIBBLES=4, driving a behavioural 4-bit slice.
// Expected results come from a full-width reference and queue up at start; they are popped on done.
module tb_alu_nibble_sequencer;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic [3:0]   op_s = '0;
  logic         op_m = 1'b0, op_cin = 1'b0;
  logic         busy, done, cout, zero;
  logic [W-1:0] result;
  logic [3:0]   alu_a, alu_b, alu_s, alu_o;
  logic         alu_m, alu_cin, alu_cout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         z;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cin(op_cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
    .alu_o(alu_o), .alu_cout(alu_cout)
  );

  // Behavioural 4-bit slice: arithmetic codes add with active-high carry-in; logic mode gives cout=0.
  logic [4:0] sum5;
  always_comb begin
    sum5     = 5'd0;
    alu_o    = alu_a ^ alu_b;
    alu_cout = 1'b0;
    if (!alu_m) begin
      case (alu_s)
        4'b1001: sum5 = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
        4'b0110: sum5 = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_cin};
        4'b0000: sum5 = {1'b0, alu_a} + {4'd0, alu_cin};
        default: sum5 = {1'b0, alu_a ^ alu_b};
      endcase
      alu_o    = sum5[3:0];
      alu_cout = sum5[4];
    end else begin
      case (alu_s)
        4'b1110: alu_o = alu_a | alu_b;
        4'b1011: alu_o = alu_a & alu_b;
        4'b0110: alu_o = alu_a ^ alu_b;
        4'b0000: alu_o = ~alu_a;
        default: alu_o = alu_a ^ alu_b;
      endcase
    end
  end

  // Whole-word reference for the same functions.
  function automatic exp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] s, input logic m, input logic ci);
    logic [W:0] full;
    exp_t e;
    full = '0;
    if (!m) begin
      case (s)
        4'b1001: full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        4'b0110: full = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ci};
        4'b0000: full = {1'b0, a} + {{W{1'b0}}, ci};
        default: full = {1'b0, a ^ b};
      endcase
    end else begin
      case (s)
        4'b1110: full = {1'b0, a | b};
        4'b1011: full = {1'b0, a & b};
        4'b0110: full = {1'b0, a ^ b};
        4'b0000: full = {1'b0, ~a};
        default: full = {1'b0, a ^ b};
      endcase
    end
    e.res = full[W-1:0];
    e.co  = full[W];
    e.z   = (full[W-1:0] == '0);
    return e;
  endfunction

  // Scoreboard: every completion must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1, required no done (scoreboard empty) at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (result !== e.res) begin
          errors++;
          $display("FAIL sb_result: got %h, required %h", result, e.res);
        end
        checks++;
        if (cout !== e.co) begin
          errors++;
          $display("FAIL sb_cout: got %b, required %b", cout, e.co);
        end
        checks++;
        if (zero !== e.z) begin
          errors++;
          $display("FAIL sb_zero: got %b, required %b", zero, e.z);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, cout, zero} !== 4'b0000 || result !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b cout=%b zero=%b result=%h, required all 0",
               busy, done, cout, zero, result);
    end
    checks++;
    if ({alu_a, alu_b, alu_s, alu_m, alu_cin} !== 14'd0) begin
      errors++;
      $display("FAIL reset_slice_drive: got a=%h b=%h s=%h m=%b cin=%b, required all 0",
               alu_a, alu_b, alu_s, alu_m, alu_cin);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  // One operation with latency, busy, hold-until-done and operand-isolation checks.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                        input logic m, input logic ci, input string name);
    int k;
    logic [W-1:0] prev;
    bit held;
    @(negedge clk);
    prev   = result;
    op_a   = a;
    op_b   = b;
    op_s   = s;
    op_m   = m;
    op_cin = ci;
    start  = 1'b1;
    exp_q.push_back(ref_op(a, b, s, m, ci));
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy: got %b, required 1", name, busy);
    end
    checks++;
    if (alu_a !== a[3:0] || alu_b !== b[3:0] || alu_cin !== ci || alu_s !== s || alu_m !== m) begin
      errors++;
      $display("FAIL %s_first_nibble: got a=%h b=%h cin=%b s=%h m=%b, required a=%h b=%h cin=%b s=%h m=%b",
               name, alu_a, alu_b, alu_cin, alu_s, alu_m, a[3:0], b[3:0], ci, s, m);
    end
    // Latched copies must be used, so live operand changes must not matter.
    op_a = W'($urandom);
    op_b = W'($urandom);
    op_s = 4'($urandom);
    held = 1'b1;
    for (k = 1; k < 20; k++) begin
      if (done) break;
      if (result !== prev) held = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: got no done in 20 cycles, required done after %0d", name, NIB);
    end else if (k - 1 != NIB) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges, required %0d", name, k - 1, NIB);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_at_done: got %b, required 0", name, busy);
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL %s_result_hold: got result change before done, required hold at %h", name, prev);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || {alu_a, alu_b, alu_s, alu_m, alu_cin} !== 14'd0) begin
      errors++;
      $display("FAIL %s_idle_after: got done=%b slice_drive=%h, required 0 0",
               name, done, {alu_a, alu_b, alu_s, alu_m, alu_cin});
    end
  endtask

  task automatic test_arith();
    run_op(16'h0FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, "add_0fff");
    run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, "add_wrap");
    run_op(16'h0005, 16'h0003, 4'b0110, 1'b0, 1'b1, "a_plus_nb");
    run_op(16'h1234, 16'h0000, 4'b0000, 1'b0, 1'b1, "a_plus_cin");
    for (int i = 0; i < 4; i++)
      run_op(W'($urandom), W'($urandom), 4'b1001, 1'b0, 1'($urandom), "add_rand");
  endtask

  task automatic test_logic();
    run_op(16'hA5C3, 16'h0FF0, 4'b1011, 1'b1, 1'b1, "and");
    run_op(16'hA5C3, 16'h0FF0, 4'b0110, 1'b1, 1'b0, "xor");
  endtask

  task automatic test_ignore_start();
    int ndone;
    int kdone;
    ndone = 0;
    kdone = -1;
    @(negedge clk);
    op_a   = 16'hF0F0;
    op_b   = 16'h0F0F;
    op_s   = 4'b1110;
    op_m   = 1'b1;
    op_cin = 1'b0;
    start  = 1'b1;
    exp_q.push_back(ref_op(16'hF0F0, 16'h0F0F, 4'b1110, 1'b1, 1'b0));
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        kdone = k;
      end
      if (k == 1) start = 1'b0;
      if (k == 2) begin
        start = 1'b1;
        op_a  = 16'h1234;
        op_b  = 16'h4321;
        op_m  = 1'b0;
        op_s  = 4'b1001;
      end
      if (k == 3) start = 1'b0;
    end
    checks++;
    if (ndone != 1 || kdone != NIB + 1) begin
      errors++;
      $display("FAIL ignore_start: got %0d dones (last at cycle %0d), required 1 at cycle %0d",
               ndone, kdone, NIB + 1);
    end
  endtask

  task automatic test_back_to_back();
    int ndone;
    bit d5, d10, held;
    ndone = 0;
    d5 = 1'b0;
    d10 = 1'b0;
    held = 1'b1;
    @(negedge clk);
    op_a   = 16'h1111;
    op_b   = 16'h2222;
    op_s   = 4'b1001;
    op_m   = 1'b0;
    op_cin = 1'b0;
    start  = 1'b1;
    exp_q.push_back(ref_op(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b0));
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done) ndone++;
      if (k == NIB + 1) d5 = done;
      if (k == 2 * NIB + 2) d10 = done;
      if (k > NIB + 1 && k < 2 * NIB + 2 && result !== 16'h3333) held = 1'b0;
      if (k == 1) begin
        // Second operands sit on the bus until the accept in the done cycle.
        op_a = 16'h1234;
        op_b = 16'h4321;
        exp_q.push_back(ref_op(16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b0));
      end
      if (k == NIB + 2) begin
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_second_busy: got %b, required 1", busy);
        end
      end
    end
    checks++;
    if (!d5 || !d10 || ndone != 2) begin
      errors++;
      $display("FAIL b2b_done_timing: got done@4=%b done@9=%b count=%0d, required 1 1 2", d5, d10, ndone);
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL b2b_result_hold: got change between dones, required 3333 held");
    end
  endtask

  task automatic test_midrun_reset();
    int ndone;
    ndone = 0;
    @(negedge clk);
    op_a   = 16'h4444;
    op_b   = 16'h1111;
    op_s   = 4'b1001;
    op_m   = 1'b0;
    op_cin = 1'b1;
    start  = 1'b1;
    exp_q.push_back(ref_op(16'h4444, 16'h1111, 4'b1001, 1'b0, 1'b1));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, cout, zero} !== 4'b0000 || result !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%b done=%b cout=%b zero=%b result=%h, required all 0",
               busy, done, cout, zero, result);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL no_done_after_reset: got %0d dones busy=%b, required 0 0", ndone, busy);
    end
    run_op(16'h8000, 16'h8000, 4'b1001, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_ignore_start();
    test_back_to_back();
    test_midrun_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_nibble_sequencer.md
# alu_nibble_sequencer

Multi-cycle controller that performs a WIDTH = 4·NIBBLES bit ALU operation by driving one external 4-bit combinational ALU slice one nibble per clock, LSB nibble first.

- Feeds the slice's a, b, s, m and cin inputs and consumes its o and cout, chaining carry between nibbles through a register.
- Sits directly upstream of the 4-bit ALU.
- Presents a start/busy/done handshake to the datapath controller above it.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit slices per operation (≥1); WIDTH = 4·NIBBLES.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- op_s  in  4  function select, passed unchanged to the slice.
- op_m  in  1  mode: 0 arithmetic, 1 logic.
- op_cin  in  1  carry into nibble 0.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  final result; holds until the next completion.
- cout  out  1  carry out of the last nibble.
- zero  out  1  result == 0.
- alu_a, alu_b  out  4  current nibble of latched operands to the slice.
- alu_s  out  4  latched op_s.
- alu_m  out  1  latched op_m.
- alu_cin  out  1  carry into the slice.
- alu_o  in  4  slice result.
- alu_cout  in  1  slice carry out.

## Operation
States and transitions:
- IDLE: start=1 → latch op_a, op_b, op_s, op_m, op_cin; clear idx and accumulator; go to RUN.
- RUN: each cycle the slice is driven with:
  - alu_a = a_reg[4·idx+3 : 4·idx], alu_b likewise from b_reg.
  - alu_s = s_reg, alu_m = m_reg.
  - alu_cin = cin_reg when idx=0, otherwise carry_reg.
- Each RUN clock edge:
  - acc[4·idx+3 : 4·idx] ← alu_o.
  - carry_reg ← alu_cout.
  - idx ← idx+1.
- Completion: on the edge where idx = NIBBLES−1:
  - result ← final accumulator including this nibble.
  - cout ← alu_cout; zero ← (that result == 0).
  - done ← 1; go to IDLE.

Mode and data rules:
- Carry is chained raw in both modes; no inversion or reinterpretation.
- In logic mode, cout reflects whatever the slice returns (0 for a conforming slice).
- In IDLE, alu_a, alu_b, alu_s, alu_m and alu_cin are driven to 0.
- No arithmetic is performed locally; all data comes from alu_o/alu_cout.
- idx width is clog2(NIBBLES), minimum 1; idx never exceeds NIBBLES−1.
- Operand changes during RUN are ignored because the latched copies are used.

Reset (rst_n=0, async, any state including mid-RUN):
- State ← IDLE.
- busy, done, cout, zero, result, accumulator, carry_reg, idx ← 0.
- An interrupted operation is discarded; no done is produced.

## Timing
- Accept edge: start sampled high in IDLE.
- busy: registered; 1 from the accept edge until the completion edge, 0 in IDLE.
- done: exactly one cycle high, asserted NIBBLES edges after the accept edge; busy falls on that same edge.
- start while busy=1: ignored, with no queueing.
- start high during the done cycle: accepted, giving back-to-back operations at NIBBLES+1 cycles each.
- result, cout, zero: change only on the completion edge, all three together.
- Combinational path: output registers → slice → alu_o/alu_cout → accumulator must close in one clock period.

## Test plan
- NIBBLES=4, m=0, s=1001 (A+B), a=0FFF, b=0001, cin=0 → after 4 edges: done=1, result=1000, cout=0, zero=0.
- m=0, s=1001, a=FFFF, b=0001, cin=0 → result=0000, cout=1, zero=1; carry propagates through all nibbles.
- m=0, s=0110 (A+~B), a=0005, b=0003, cin=1 → result=0002, cout=1.
- m=1, s=1110 (A|B), a=F0F0, b=0F0F → result=FFFF, cout=0. Also pulse start again at cycle 2 → ignored; exactly one done.
- Start, then hold start high through the done cycle → second op accepted. Dones at edges 4 and 9 after the first accept. Values change only at done.
- Assert rst_n=0 at RUN idx=2 → busy, done, result and cout are 0 immediately. After release, no done occurs until a new start.
